// File: rtl/burst_addr_sched.sv
// burst_addr_sched: round-robin arbiter in front of one shared buffer-address
// sequencer. A granted requester receives a run of consecutive addresses
// (wrapping at MAX_DATA), one beat per unstalled cycle, followed by a
// one-cycle completion pulse tagged with the requester index.
module burst_addr_sched #(
  parameter int MAX_DATA = 256,
  parameter int NREQ = 2,
  localparam int AWIDTH = $clog2(MAX_DATA),
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*AWIDTH-1:0]     start_addr,
  input  logic [NREQ*(AWIDTH+1)-1:0] burst_len,
  input  logic                       stall,
  output logic [NREQ-1:0]            gnt,
  output logic                       mem_en,
  output logic [AWIDTH-1:0]          mem_addr,
  output logic                       busy,
  output logic                       done,
  output logic [IDW-1:0]             done_id
);

  localparam logic [AWIDTH:0]   MAX_LEN   = (AWIDTH+1)'(MAX_DATA);
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(MAX_DATA - 1);
  localparam logic [IDW-1:0]    LAST_ID   = IDW'(NREQ - 1);
  localparam logic [IDW:0]      NREQ_W    = (IDW+1)'(NREQ);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t            state, state_n;
  logic [IDW-1:0]    ptr, ptr_n;
  logic [IDW-1:0]    cur_id, cur_id_n;
  logic [AWIDTH:0]   remain, remain_n;
  logic [NREQ-1:0]   gnt_n;
  logic              mem_en_n;
  logic [AWIDTH-1:0] mem_addr_n;
  logic              done_n;
  logic [IDW-1:0]    done_id_n;

  logic              found;
  logic [IDW-1:0]    sel;
  logic [IDW:0]      cand;
  logic [AWIDTH:0]   sel_len_raw;
  logic [AWIDTH:0]   sel_len;
  logic [AWIDTH-1:0] sel_start;

  assign busy = (state != IDLE);

  // Pick the first requesting index at or after the pointer, cyclically, and
  // fetch its start address and clamped length.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!found && req[cand[IDW-1:0]]) begin
        found = 1'b1;
        sel   = cand[IDW-1:0];
      end
    end
    sel_start   = start_addr[sel*AWIDTH +: AWIDTH];
    sel_len_raw = burst_len[sel*(AWIDTH+1) +: (AWIDTH+1)];
    sel_len     = (sel_len_raw > MAX_LEN) ? MAX_LEN : sel_len_raw;
  end

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    cur_id_n   = cur_id;
    remain_n   = remain;
    gnt_n      = gnt;
    mem_en_n   = mem_en;
    mem_addr_n = mem_addr;
    done_n     = 1'b0;
    done_id_n  = done_id;
    case (state)
      IDLE: begin
        if (found) begin
          cur_id_n = sel;
          gnt_n    = NREQ'(1) << sel;
          ptr_n    = (sel == LAST_ID) ? '0 : sel + IDW'(1);
          if (sel_len == '0) begin
            state_n   = DONE;
            done_n    = 1'b1;
            done_id_n = sel;
          end else begin
            state_n    = BURST;
            mem_en_n   = 1'b1;
            mem_addr_n = sel_start;
            remain_n   = sel_len;
          end
        end
      end
      BURST: begin
        if (!stall) begin
          if (remain == (AWIDTH+1)'(1)) begin
            // Last beat: leave the final address on the bus and report.
            state_n   = DONE;
            mem_en_n  = 1'b0;
            remain_n  = '0;
            done_n    = 1'b1;
            done_id_n = cur_id;
          end else begin
            remain_n   = remain - (AWIDTH+1)'(1);
            mem_addr_n = (mem_addr == LAST_ADDR) ? '0 : mem_addr + AWIDTH'(1);
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
      default: begin
        state_n  = IDLE;
        gnt_n    = '0;
        mem_en_n = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      cur_id   <= '0;
      remain   <= '0;
      gnt      <= '0;
      mem_en   <= 1'b0;
      mem_addr <= '0;
      done     <= 1'b0;
      done_id  <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      cur_id   <= cur_id_n;
      remain   <= remain_n;
      gnt      <= gnt_n;
      mem_en   <= mem_en_n;
      mem_addr <= mem_addr_n;
      done     <= done_n;
      done_id  <= done_id_n;
    end
  end

endmodule

// File: tb/tb_burst_addr_sched.sv
// Testbench for burst_addr_sched with MAX_DATA=256, NREQ=2.
module tb_burst_addr_sched;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [15:0] start_addr;
  logic [17:0] burst_len;
  logic        stall;
  logic [1:0]  gnt;
  logic        mem_en;
  logic [7:0]  mem_addr;
  logic        busy;
  logic        done;
  logic [0:0]  done_id;

  int checks;
  int failures;
  int cur_vec;

  typedef struct {
    logic [1:0] req;
    logic [7:0] s0;
    logic [7:0] s1;
    logic [8:0] l0;
    logic [8:0] l1;
    int         stall_from;
    int         stall_cnt;
    logic [1:0] exp_gnt;
    logic       exp_id;
    int         exp_beats;
    int         exp_cycles;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vecs[7];

  burst_addr_sched #(.MAX_DATA(256), .NREQ(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .start_addr (start_addr),
    .burst_len  (burst_len),
    .stall      (stall),
    .gnt        (gnt),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .busy       (busy),
    .done       (done),
    .done_id    (done_id)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic [1:0] r, input logic [7:0] s0, input logic [7:0] s1,
                               input logic [8:0] l0, input logic [8:0] l1);
    req        = r;
    start_addr = {s1, s0};
    burst_len  = {l1, l0};
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s (vector %0d) at %0t: got %0d, expected %0d", name, cur_vec, $time, act, exp);
    end
  endtask

  // One complete burst: drive the request in IDLE, follow the beats with a
  // running address model, then check the completion cycle and return to IDLE.
  task automatic runVector(input vec_t v);
    logic [7:0] exp_addr;
    int beats;
    int cyc;
    logic s;
    applyStimulus(v.req, v.s0, v.s1, v.l0, v.l1);
    stall = 1'b0;
    @(negedge clk);
    checkOutput("gnt", 32'(gnt), 32'(v.exp_gnt));
    checkOutput("busy", 32'(busy), 32'd1);
    exp_addr = v.exp_first;
    beats = 0;
    cyc = 0;
    while (mem_en === 1'b1 && cyc < 600) begin
      checkOutput("mem_addr", 32'(mem_addr), 32'(exp_addr));
      s = (cyc >= v.stall_from) && (cyc < v.stall_from + v.stall_cnt);
      stall = s;
      if (!s) begin
        beats++;
        exp_addr = exp_addr + 8'd1;
      end
      cyc++;
      @(negedge clk);
    end
    stall = 1'b0;
    checkOutput("beats", 32'(beats), 32'(v.exp_beats));
    checkOutput("burst_cycles", 32'(cyc), 32'(v.exp_cycles));
    checkOutput("done", 32'(done), 32'd1);
    checkOutput("done_id", 32'(done_id), 32'(v.exp_id));
    checkOutput("gnt_in_done", 32'(gnt), 32'(v.exp_gnt));
    checkOutput("mem_en_in_done", 32'(mem_en), 32'd0);
    checkOutput("last_addr", 32'(mem_addr), 32'(v.exp_last));
    req = 2'b00;
    @(negedge clk);
    checkOutput("done_after", 32'(done), 32'd0);
    checkOutput("busy_after", 32'(busy), 32'd0);
    checkOutput("gnt_after", 32'(gnt), 32'd0);
  endtask

  // Main sequence: reset, vector table, round-robin run, reset mid-burst.
  initial begin
    logic [1:0] exp_g;
    logic [7:0] base;
    vec_t post;
    checks = 0;
    failures = 0;
    cur_vec = -1;
    rst_n = 1'b0;
    stall = 1'b0;
    applyStimulus(2'b00, 8'd0, 8'd0, 9'd0, 9'd0);

    vecs[0] = '{2'b01, 8'd10,  8'd0,   9'd4, 9'd0,   0, 0, 2'b01, 1'b0, 4,   4,   8'd10,  8'd13};
    vecs[1] = '{2'b01, 8'd254, 8'd0,   9'd4, 9'd0,   0, 0, 2'b01, 1'b0, 4,   4,   8'd254, 8'd1};
    vecs[2] = '{2'b10, 8'd0,   8'd5,   9'd0, 9'd3,   1, 2, 2'b10, 1'b1, 3,   5,   8'd5,   8'd7};
    vecs[3] = '{2'b01, 8'd0,   8'd0,   9'd0, 9'd0,   0, 0, 2'b01, 1'b0, 0,   0,   8'd0,   8'd7};
    vecs[4] = '{2'b10, 8'd0,   8'd100, 9'd0, 9'd300, 0, 0, 2'b10, 1'b1, 256, 256, 8'd100, 8'd99};
    vecs[5] = '{2'b11, 8'd20,  8'd30,  9'd1, 9'd1,   0, 0, 2'b01, 1'b0, 1,   1,   8'd20,  8'd20};
    vecs[6] = '{2'b11, 8'd20,  8'd30,  9'd1, 9'd1,   0, 0, 2'b10, 1'b1, 1,   1,   8'd30,  8'd30};

    repeat (2) @(negedge clk);
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_done_id", 32'(done_id), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      cur_vec = i;
      runVector(vecs[i]);
    end

    // Both requesters held: four len-2 bursts, 4 cycles each, alternating.
    cur_vec = 100;
    applyStimulus(2'b11, 8'd40, 8'd60, 9'd2, 9'd2);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      exp_g = ((c / 4) % 2 == 0) ? 2'b01 : 2'b10;
      base  = ((c / 4) % 2 == 0) ? 8'd40 : 8'd60;
      checkOutput("rr_gnt", 32'(gnt), (c % 4 < 3) ? 32'(exp_g) : 32'd0);
      checkOutput("rr_mem_en", 32'(mem_en), (c % 4 < 2) ? 32'd1 : 32'd0);
      checkOutput("rr_done", 32'(done), (c % 4 == 2) ? 32'd1 : 32'd0);
      if (c % 4 < 2) checkOutput("rr_mem_addr", 32'(mem_addr), 32'(base) + 32'(c % 4));
      if (c % 4 == 2) checkOutput("rr_done_id", 32'(done_id), 32'((c / 4) % 2));
      if (c == 14) req = 2'b00;
    end

    // Reset on the third beat of an 8-beat burst.
    cur_vec = 200;
    applyStimulus(2'b01, 8'd50, 8'd0, 9'd8, 9'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("mid_mem_addr", 32'(mem_addr), 32'd50 + 32'(c));
    end
    rst_n = 1'b0;
    req = 2'b00;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput("mid_rst_gnt", 32'(gnt), 32'd0);
      checkOutput("mid_rst_mem_en", 32'(mem_en), 32'd0);
      checkOutput("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
      checkOutput("mid_rst_done", 32'(done), 32'd0);
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_done", 32'(done), 32'd0);

    // Pointer must be back at 0, so requester 0 wins a simultaneous request.
    cur_vec = 300;
    post = '{2'b11, 8'd70, 8'd80, 9'd1, 9'd1, 0, 0, 2'b01, 1'b0, 1, 1, 8'd70, 8'd70};
    runVector(post);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/burst_addr_sched.md
# burst_addr_sched

Round-robin scheduler that shares a single buffer-address sequencer among `NREQ` requesters. Each requester asks for a burst of consecutive buffer addresses from a start address and length. The block grants one requester at a time and drives the shared buffer's enable and address one beat per cycle, wrapping at `MAX_DATA`. It reports completion per burst and sits between the requesting engines and the shared sample buffer.

## Interface
Parameters:
- `MAX_DATA`, 256, buffer depth in entries; `AWIDTH = $clog2(MAX_DATA)` (local).
- `NREQ`, 2, number of requesters, 2..8; `IDW = max(1,$clog2(NREQ))` (local).

Ports:
- `clk`  in  1  single clock, all logic on posedge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req`  in  NREQ  per-requester burst request, level.
- `start_addr`  in  NREQ*AWIDTH  packed start addresses; requester i at `[i*AWIDTH +: AWIDTH]`.
- `burst_len`  in  NREQ*(AWIDTH+1)  packed lengths, 0..MAX_DATA; requester i at `[i*(AWIDTH+1) +: AWIDTH+1]`.
- `stall`  in  1  back-pressure from buffer; holds the current beat.
- `gnt`  out  NREQ  one-hot grant, registered.
- `mem_en`  out  1  beat valid to buffer, registered.
- `mem_addr`  out  AWIDTH  beat address, registered.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `done_id`  out  IDW  index of the requester whose burst completed; valid with `done`.

## Operation
- Reset (`rst_n` low at a posedge):
  - State goes to IDLE.
  - `gnt`=0, `mem_en`=0, `mem_addr`=0, `busy`=0, `done`=0, `done_id`=0.
  - Round-robin pointer goes to 0, so requester 0 has highest priority first.
  - Reset mid-burst aborts the burst. No `done` is issued.
- States: IDLE, BURST, DONE.
- IDLE:
  - When any `req` bit is high, select the first requester at or after the pointer, in cyclic order.
  - Latch that requester's `start_addr` and `burst_len`.
  - Lengths above MAX_DATA clamp to MAX_DATA.
  - Assert `gnt` for the selected requester.
  - Move the pointer to the selected index + 1, mod `NREQ`.
  - If the latched length is 0, go to DONE. Otherwise go to BURST with `mem_en`=1 and `mem_addr`=start.
- BURST:
  - A beat completes on each cycle with `mem_en`=1 and `stall`=0.
  - `stall`=1 holds `mem_addr` and the remaining count. `mem_en` stays high.
  - After each completed beat, the address increments. MAX_DATA-1 wraps to 0.
  - After each completed beat, the remaining count decrements.
  - When the last beat completes, deassert `mem_en` and go to DONE.
- DONE:
  - `done`=1 and `done_id` = granted index for exactly one cycle. `gnt` stays high.
  - Next state is IDLE; `gnt` clears on entry.
- Request inputs are sampled only in IDLE. `req`, address and length changes during BURST or DONE have no effect.
- Dropping `req` mid-burst does not abort the burst.
- Requester protocol: deassert `req` on or after the cycle `done` is seen. Otherwise the requester re-arbitrates.
- Requests that arrive simultaneously resolve by the pointer only. Index order matters only relative to the pointer.

## Timing
- Example: `req` seen in IDLE at edge T.
  - `gnt` and the first `mem_en`/`mem_addr` are visible after edge T.
  - With no stall, N beats occupy cycles T+1..T+N.
  - `done` is in cycle T+N+1.
  - IDLE is in cycle T+N+2.
  - The earliest next grant is after edge T+N+2.
- Overhead per burst: 2 cycles (DONE + IDLE), plus stall cycles.
- Zero-length burst:
  - `gnt` and `done` in cycle T+1.
  - `mem_en` never asserts.
- Full-length burst: `burst_len`=MAX_DATA visits every address exactly once and ends with `mem_addr` = start-1 mod MAX_DATA.
- Throughput: one beat per cycle when `stall`=0.
- `mem_en` is never high outside BURST.

## Test plan
- Reset, then one burst:
  - Stimulus: `rst_n` low 2 cycles; `req[0]`=1, start=10, len=4.
  - Required: all outputs 0 during reset; `gnt`=01; `mem_addr` 10,11,12,13 with `mem_en` high for 4 cycles; `done`=1 with `done_id`=0 in the next cycle; `busy` low after.
- Wrap-around:
  - Stimulus: start=254, len=4, MAX_DATA=256.
  - Required: addresses 254,255,0,1; then `done`.
- Round-robin:
  - Stimulus: `req`=11 held continuously, each len=2.
  - Required: grants alternate 01,10,01,10; `done_id` alternates 0,1,0,1; 4 cycles per burst.
- Stall:
  - Stimulus: len=3, start=5; `stall`=1 for 2 cycles during the second beat.
  - Required: `mem_addr` holds 6 for 3 cycles with `mem_en` high; beats 5,6,7 each complete once; `done` is 2 cycles later than in the unstalled run.
- Zero length and clamp:
  - Zero length stimulus: len=0.
  - Zero length required: `done` in cycle T+1 and no `mem_en`.
  - Clamp stimulus: len=300 with MAX_DATA=256.
  - Clamp required: exactly 256 beats.
- Reset mid-burst:
  - Stimulus: `rst_n` low at the third beat of an 8-beat burst.
  - Required: next cycle `gnt`=0, `mem_en`=0, `mem_addr`=0, no `done`; the pointer returns to 0.
